// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receiver FSM states. PARITY is only entered when UART_RX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Parity sense selectors for PARITY_ODD.
    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Stop period lengths in sample ticks, assuming 16x oversampling.
    localparam int STOP_1   = 16;
    localparam int STOP_1P5 = 24;
    localparam int STOP_2   = 32;

    // Larger of two integers, used to size the shared tick counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the line into the clk domain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receive engine: start/data/[parity]/stop framing,
// framing and overrun detection, and a one-word valid/ready holding register.
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit after the data.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int N          = 8,
    parameter int OVS        = 16,
    parameter int SB_TICK    = STOP_1,
    parameter int PARITY_ODD = PAR_EVEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    input  logic         sample_tick,
    output logic [N-1:0] dout,
    output logic         rx_done,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun
);

    localparam int SW = $clog2(max_int(OVS, SB_TICK));
    localparam int NW = $clog2(N);

    localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic          PAR_SENSE = (PARITY_ODD != 0);

    logic rx_s;

    rx_state_e     state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [NW-1:0] n_q, n_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic          ferr_n_q, ferr_n_d;
    logic          perr_n;
    logic          done_pend_q, done_pend_d;
    logic          armed_q, armed_d;

    logic [N-1:0]  dout_q;
    logic          rx_done_q, rx_valid_q, frame_err_q, parity_err_q, overrun_q;

    uart_rx_sync u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic perr_n_q, perr_n_d;
    assign perr_n = perr_n_q;
`else
    // Without a parity bit there is nothing to mismatch; PARITY_ODD has no effect.
    assign perr_n = PAR_SENSE & 1'b0;
`endif

    // Frame FSM state, counters, shift register and per-frame error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shreg_q     <= '0;
            ferr_n_q    <= 1'b0;
            done_pend_q <= 1'b0;
            armed_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_n_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shreg_q     <= shreg_d;
            ferr_n_q    <= ferr_n_d;
            done_pend_q <= done_pend_d;
            armed_q     <= armed_d;
`ifdef UART_RX_PARITY_EN
            perr_n_q    <= perr_n_d;
`endif
        end
    end

    // Next-state logic: advance on sample ticks, except start-edge detection in IDLE.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        shreg_d     = shreg_q;
        ferr_n_d    = ferr_n_q;
        done_pend_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n_d    = perr_n_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s && armed_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        shreg_d = {rx_s, shreg_q[N-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (sample_tick) begin
                    if (s_q == S_BIT) begin
                        s_d      = '0;
                        perr_n_d = rx_s ^ (^shreg_q) ^ PAR_SENSE;
                        state_d  = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (sample_tick) begin
                    if (s_q == S_STOP) begin
                        s_d         = '0;
                        ferr_n_d    = ~rx_s;
                        done_pend_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A low stop bit disarms start detection until the line has been seen high.
        armed_d = rx_s | (armed_q & ~(done_pend_d & ~rx_s));
    end

    // Completion and holding register: load, flag overrun, or release on read.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            rx_done_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_done_q <= done_pend_q;
            overrun_q <= 1'b0;
            if (done_pend_q) begin
                if (!rx_valid_q || rx_ready) begin
                    dout_q       <= shreg_q;
                    frame_err_q  <= ferr_n_q;
                    parity_err_q <= perr_n;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign dout      = dout_q;
    assign rx_done   = rx_done_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
    logic unused_perr;
    assign unused_perr = parity_err_q;
`endif
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at default parameters, sample tick every 4 clocks.
// Expected completions are queued when a frame is sent and checked on each rx_done.
module tb_uart_rx_frame;

    localparam int BIT_CLKS = 64;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       sample_tick = 1'b0;
    logic [7:0] dout;
    logic       rx_done, rx_valid, rx_ready, frame_err, parity_err, overrun;

    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   ovr_cnt  = 0;
    int   tick_cnt = 0;
    exp_t exp_q[$];

    uart_rx_frame dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .sample_tick (sample_tick),
        .dout        (dout),
        .rx_done     (rx_done),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_cnt    <= (tick_cnt == 3) ? 0 : tick_cnt + 1;
        sample_tick <= (tick_cnt == 3);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rx_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (overrun === 1'b1) ovr_cnt++;
            if (overrun === 1'b1 && rx_done !== 1'b1) chk("overrun_without_done", 32'(rx_done), 1);
            if (rx_done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rx_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dout", 32'(dout), 32'(e.d));
                    chk("frame_err", 32'(frame_err), 32'(e.fe));
                    chk("parity_err", 32'(parity_err), 32'(e.pe));
                    chk("overrun", 32'(overrun), 32'(e.ov));
                    chk("rx_valid_at_done", 32'(rx_valid), 1);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic use_par, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(par_b);
        send_bit(stop_b);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe, input logic ov);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe; e.ov = ov;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int base;
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_done", 32'(rx_done), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_parity_err", 32'(parity_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);

        // 1: clean 0xA5 frame
        base = done_cnt;
        push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_drain();
        chk("t1_done_count", 32'(done_cnt - base), 1);

        // 2: start glitch of 4 ticks is rejected
        base = done_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT_CLKS) @(negedge clk);
        chk("t2_no_done", 32'(done_cnt - base), 0);
        chk("t2_dout_held", 32'(dout), 32'h A5);

        // 3: stop bit low gives a framing error
        push_exp(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // 4: overrun while the holding register is full
        base = ovr_cnt;
        rx_ready = 1'b0;
        push_exp(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        push_exp(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        wait_drain();
        chk("t4_overrun_count", 32'(ovr_cnt - base), 1);
        chk("t4_valid_held", 32'(rx_valid), 1);
        chk("t4_dout_kept", 32'(dout), 32'h11);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        chk("t4_valid_cleared", 32'(rx_valid), 0);
        chk("t4_dout_after_read", 32'(dout), 32'h11);
        rx_ready = 1'b1;

`ifdef UART_RX_PARITY_EN
        // 5: even parity on 0x07 (three ones, correct parity bit is 1)
        push_exp(8'h07, 1'b0, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        push_exp(8'h07, 1'b0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        wait_drain();
`endif

        // 6: reset during data bit 3 aborts the frame
        base = done_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (BIT_CLKS / 2) @(negedge clk);
        rx = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_dout", 32'(dout), 0);
        chk("t6_rst_valid", 32'(rx_valid), 0);
        chk("t6_rst_frame_err", 32'(frame_err), 0);
        chk("t6_rst_overrun", 32'(overrun), 0);
        repeat (4 * BIT_CLKS) @(negedge clk);
        chk("t6_no_partial_done", 32'(done_cnt - base), 0);
        push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        wait_drain();
        chk("t6_done_count", 32'(done_cnt - base), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
